// File: rtl/ac_probe_meter.sv
// ac_probe_meter: windowed statistics probe for a signed sample stream.
// Accumulates 2^LOG2_N accepted samples and reports mean (floor), min, max
// and peak-to-peak through a valid/ready result register. A completed window
// that finds an unread, unaccepted result is dropped and flagged as overrun.
module ac_probe_meter #(
    parameter int W      = 12,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [W-1:0]      sample_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [W-1:0]      mean,
    output logic [W-1:0]      min_val,
    output logic [W-1:0]      max_val,
    output logic [W:0]        pk_pk,
    output logic [15:0]       window_cnt,
    output logic              overrun,
    input  logic              clear_ovr
);

    // Sum width grows by LOG2_N bits so a full window of extremes cannot overflow.
    localparam int SW = W + LOG2_N;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACQ  = 1'b1;

    logic [0:0]               state_reg;
    logic signed [SW-1:0]     sum_reg;
    logic signed [W-1:0]      min_reg;
    logic signed [W-1:0]      max_reg;
    logic [LOG2_N-1:0]        cnt_reg;

    logic signed [W-1:0]      sample_s;
    logic signed [SW-1:0]     sample_ext;
    logic                     accept;
    logic                     first;
    logic                     last;
    logic                     load;
    logic                     drop;
    logic signed [SW-1:0]     sum_upd;
    logic signed [SW-1:0]     sum_shift;
    logic signed [W-1:0]      min_upd;
    logic signed [W-1:0]      max_upd;
    logic [W-1:0]             mean_calc;
    logic [W:0]               pk_calc;

    assign sample_s   = $signed(sample_data);
    assign sample_ext = {{LOG2_N{sample_data[W-1]}}, sample_data};

    // Tracker updates including the current sample; a window's first sample
    // seeds min/max since the trackers hold stale data when the count is zero.
    always_comb begin
        accept    = (state_reg == ST_ACQ) && enable && sample_valid;
        first     = (cnt_reg == '0);
        last      = accept && (cnt_reg == {LOG2_N{1'b1}});
        load      = last && (!result_valid || result_ready);
        drop      = last && result_valid && !result_ready;
        sum_upd   = sum_reg + sample_ext;
        sum_shift = sum_upd >>> LOG2_N;
        min_upd   = (first || (sample_s < min_reg)) ? sample_s : min_reg;
        max_upd   = (first || (sample_s > max_reg)) ? sample_s : max_reg;
        mean_calc = sum_shift[W-1:0];
        pk_calc   = {max_upd[W-1], max_upd} - {min_upd[W-1], min_upd};
    end

    // Acquisition state and per-window accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sum_reg   <= '0;
            min_reg   <= '0;
            max_reg   <= '0;
            cnt_reg   <= '0;
        end else if (state_reg == ST_IDLE) begin
            // Every entry into ACQ starts a fresh window.
            sum_reg <= '0;
            cnt_reg <= '0;
            if (enable) begin
                state_reg <= ST_ACQ;
            end
        end else if (!enable) begin
            // Partial window is abandoned; the sample in this cycle is ignored.
            state_reg <= ST_IDLE;
            sum_reg   <= '0;
            cnt_reg   <= '0;
        end else if (last) begin
            sum_reg <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            sum_reg <= sum_upd;
            min_reg <= min_upd;
            max_reg <= max_upd;
            cnt_reg <= cnt_reg + LOG2_N'(1);
        end
    end

    // Result register, handshake, window counter and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            mean         <= '0;
            min_val      <= '0;
            max_val      <= '0;
            pk_pk        <= '0;
            window_cnt   <= '0;
            overrun      <= 1'b0;
        end else begin
            if (load) begin
                result_valid <= 1'b1;
                mean         <= mean_calc;
                min_val      <= min_upd;
                max_val      <= max_upd;
                pk_pk        <= pk_calc;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            if (last) begin
                window_cnt <= window_cnt + 16'd1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ac_probe_meter.sv
// Testbench for ac_probe_meter: scoreboard of expected window results pushed
// when the completing sample is driven, popped when the DUT result is accepted.
module tb_ac_probe_meter;

    localparam int W = 12;
    localparam int L = 2;

    typedef struct {
        logic [W-1:0] mean;
        logic [W-1:0] mn;
        logic [W-1:0] mx;
        logic [W:0]   pk;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          sample_valid;
    logic [W-1:0]  sample_data;
    logic          result_valid;
    logic          result_ready;
    logic [W-1:0]  mean, min_val, max_val;
    logic [W:0]    pk_pk;
    logic [15:0]   window_cnt;
    logic          overrun;
    logic          clear_ovr;

    // second instance at the N=2 boundary
    logic          en2, sv2;
    logic [W-1:0]  sd2;
    logic          rv2;
    logic [W-1:0]  m2, mn2, mx2;
    logic [W:0]    pk2;
    logic [15:0]   wc2;
    logic          ov2;

    int tests_run = 0;
    int tests_failed = 0;

    res_t q[$];
    int   m_sum, m_min, m_max, m_cnt;
    int   exp_wcnt;
    logic exp_ovr;
    logic tb_acq;
    int   rdy_cfg;   // 0: ready high, 1: ready low, 2: random
    logic clr_cfg;

    always #5 clk = ~clk;

    ac_probe_meter #(.W(W), .LOG2_N(L)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
        .sample_data(sample_data), .result_valid(result_valid), .result_ready(result_ready),
        .mean(mean), .min_val(min_val), .max_val(max_val), .pk_pk(pk_pk),
        .window_cnt(window_cnt), .overrun(overrun), .clear_ovr(clear_ovr)
    );

    ac_probe_meter #(.W(W), .LOG2_N(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .sample_valid(sv2),
        .sample_data(sd2), .result_valid(rv2), .result_ready(1'b1),
        .mean(m2), .min_val(mn2), .max_val(mx2), .pk_pk(pk2),
        .window_cnt(wc2), .overrun(ov2), .clear_ovr(1'b0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic model_clear();
        m_sum = 0;
        m_cnt = 0;
    endtask

    // One clock of stimulus; the reference model sees exactly what the DUT accepts.
    task automatic tick(input logic e, input logic v, input logic [W-1:0] d);
        int s, mv, pv;
        res_t r;
        logic last;
        @(posedge clk); #1;
        enable       = e;
        sample_valid = v;
        sample_data  = d;
        clear_ovr    = clr_cfg;
        result_ready = (rdy_cfg == 0) ? 1'b1 : (rdy_cfg == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        last = 1'b0;
        if (tb_acq && e && v) begin
            s = int'($signed(d));
            if (m_cnt == 0) begin
                m_min = s;
                m_max = s;
            end else begin
                if (s < m_min) m_min = s;
                if (s > m_max) m_max = s;
            end
            m_sum += s;
            m_cnt++;
            if (m_cnt == (1 << L)) begin
                last = 1'b1;
                mv = m_sum >>> L;
                pv = m_max - m_min;
                r.mean = mv[W-1:0];
                r.mn   = m_min[W-1:0];
                r.mx   = m_max[W-1:0];
                r.pk   = pv[W:0];
                exp_wcnt++;
                if (q.size() != 0 && !result_ready) exp_ovr = 1'b1;
                else q.push_back(r);
                model_clear();
            end
        end
        if (!last && clr_cfg) exp_ovr = 1'b0;
        tb_acq = e;
        if (!e) model_clear();
    endtask

    task automatic status_check(input string tag);
        tick(enable, 1'b0, '0);
        check({tag, "_wcnt"}, window_cnt, exp_wcnt);
        check({tag, "_ovr"}, overrun, exp_ovr);
    endtask

    // Result checker: compare on every accepted result.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && result_valid && result_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = q.pop_front();
                $display("[TB] result mean=%0d min=%0d max=%0d pk=%0d wcnt=%0d",
                         $signed(mean), $signed(min_val), $signed(max_val), pk_pk, window_cnt);
                check("mean", mean, e.mean);
                check("min_val", min_val, e.mn);
                check("max_val", max_val, e.mx);
                check("pk_pk", pk_pk, e.pk);
            end
        end
    end

    task automatic reset_model();
        q.delete();
        model_clear();
        exp_wcnt = 0;
        exp_ovr  = 1'b0;
        tb_acq   = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rd;
        int gap;
        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
        result_ready = 1'b1; clear_ovr = 1'b0;
        en2 = 1'b0; sv2 = 1'b0; sd2 = '0;
        rdy_cfg = 0; clr_cfg = 1'b0;
        reset_model();

        // reset state
        @(posedge clk); #1;
        check("rst_valid", result_valid, 0);
        check("rst_mean", mean, 0);
        check("rst_pk", pk_pk, 0);
        check("rst_wcnt", window_cnt, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;

        // basic window, 1-cycle latency
        tick(1, 0, '0);
        tick(1, 1, 12'd100);
        tick(1, 1, -12'sd20);
        tick(1, 1, 12'd300);
        tick(1, 1, 12'd40);
        check("lat_pre_valid", result_valid, 0);
        tick(1, 0, '0);
        check("lat_valid", result_valid, 1);
        check("lat_wcnt", window_cnt, exp_wcnt);

        // floor mean and signed extremes
        tick(1, 1, -12'sd1);
        tick(1, 1, -12'sd2);
        tick(1, 1, -12'sd1);
        tick(1, 1, -12'sd1);
        tick(1, 1, 12'h800);
        tick(1, 1, 12'h7FF);
        tick(1, 1, 12'd0);
        tick(1, 1, 12'd0);
        tick(1, 0, '0);
        tick(1, 0, '0);

        // overrun: ready low across two windows
        rdy_cfg = 1;
        tick(1, 1, 12'd1); tick(1, 1, 12'd2); tick(1, 1, 12'd3); tick(1, 1, 12'd4);
        tick(1, 1, 12'd50); tick(1, 1, 12'd50); tick(1, 1, 12'd50); tick(1, 1, 12'd50);
        status_check("ovr_set");
        check("ovr_held_valid", result_valid, 1);
        clr_cfg = 1'b1;
        tick(1, 0, '0);
        clr_cfg = 1'b0;
        status_check("ovr_clr");
        check("ovr_held_mean", mean, q[0].mean);

        // accept on the very cycle the next result loads
        tick(1, 1, 12'd7); tick(1, 1, 12'd7); tick(1, 1, 12'd7);
        rdy_cfg = 0;
        tick(1, 1, 12'd7);
        rdy_cfg = 1;
        status_check("pulse");
        check("pulse_valid", result_valid, 1);
        check("pulse_mean", mean, q[0].mean);
        rdy_cfg = 0;
        tick(1, 0, '0);
        tick(1, 0, '0);

        // enable drop mid-window, sample in the falling cycle ignored
        tick(1, 1, 12'd500); tick(1, 1, 12'd500);
        tick(0, 1, 12'd999);
        tick(0, 0, '0);
        tick(1, 0, '0);
        tick(1, 1, 12'd10); tick(1, 1, 12'd10); tick(1, 1, 12'd10); tick(1, 1, 12'd10);
        status_check("reen");
        tick(1, 0, '0);

        // asynchronous reset mid-window with a pending result
        rdy_cfg = 1;
        tick(1, 1, 12'd3); tick(1, 1, 12'd3); tick(1, 1, 12'd3); tick(1, 1, 12'd3);
        tick(1, 1, 12'd1); tick(1, 1, 12'd1);
        check("pre_rst_valid", result_valid, 1);
        @(posedge clk); #2;
        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
        #1;
        check("arst_valid", result_valid, 0);
        check("arst_mean", mean, 0);
        check("arst_max", max_val, 0);
        check("arst_wcnt", window_cnt, 0);
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // random stream with gaps and random ready
        rdy_cfg = 2;
        tick(1, 0, '0);
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                rd = 12'($urandom);
                tick(1, 0, rd);
            end
            rd = 12'($urandom);
            tick(1, 1, rd);
        end
        rdy_cfg = 0;
        for (int k = 0; k < 50 && q.size() != 0; k++) tick(1, 0, '0);
        check("rand_drained", q.size(), 0);
        check("rand_wcnt", window_cnt, 250);
        check("rand_ovr", overrun, exp_ovr);

        // N=2 instance
        @(posedge clk); #1; en2 = 1'b1;
        @(posedge clk); #1; sv2 = 1'b1; sd2 = 12'd5;
        @(posedge clk); #1; sd2 = -12'sd4;
        @(posedge clk); #1; sv2 = 1'b0;
        check("n2_valid", rv2, 1);
        check("n2_mean", m2, 0);
        check("n2_min", mn2, 12'hFFC);
        check("n2_max", mx2, 5);
        check("n2_pk", pk2, 9);
        check("n2_wcnt", wc2, 1);
        @(posedge clk); #1; sv2 = 1'b1; sd2 = -12'sd3;
        @(posedge clk); #1; sd2 = -12'sd4;
        @(posedge clk); #1; sv2 = 1'b0;
        check("n2_mean2", m2, 12'hFFC);
        check("n2_pk2", pk2, 1);
        check("n2_wcnt2", wc2, 2);
        check("n2_ovr", ov2, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ac_probe_meter.md
Name: ac_probe_meter

Overview:
- Digital measurement probe and the receiving counterpart to the AC and DC stimulus sources of the simulator's sources section.
- Consumes a stream of signed samples, such as a sampled node voltage or branch current, over a fixed window of 2^LOG2_N samples.
- Reports mean, minimum, maximum and peak-to-peak per window over a valid/ready result interface.
- Used by behavioural testbenches and mixed-signal models to check what a source actually delivered.

Parameters:
- W, 12, sample width in bits, signed two's complement (range 2..32).
- LOG2_N, 4, log2 of the window length; N = 2^LOG2_N samples per window (range 1..16).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  acquisition enable; level sensitive.
- sample_valid  in  1  sample_data is valid this cycle. No backpressure: a sample is always accepted when enable=1.
- sample_data  in  W  signed sample.
- result_valid  out  1  result registers hold an unread result.
- result_ready  in  1  consumer accepts the result when result_valid & result_ready.
- mean  out  W  signed window mean.
- min_val  out  W  signed window minimum.
- max_val  out  W  signed window maximum.
- pk_pk  out  W+1  unsigned max_val - min_val.
- window_cnt  out  16  number of windows completed; wraps 0xFFFF->0.
- overrun  out  1  sticky flag: a completed window was dropped.
- clear_ovr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; state IDLE; accumulators, sample counter and window_cnt cleared.
- State IDLE: no sample accepted. enable=1 -> ACQ next cycle with sum=0, count=0, min/max trackers invalid.
- State ACQ, each cycle with sample_valid=1:
  - sum += sign-extended sample_data; sum width is W+LOG2_N, so it cannot overflow.
  - The first sample of a window loads both the min and max trackers; later samples compare as signed.
  - count increments.
- Window completion: the sample accepted with count == N-1 completes the window, with the final sample included in sum/min/max.
  - The next cycle, the result registers load: mean = sum arithmetic-shifted right by LOG2_N (floor toward -inf); min_val; max_val; pk_pk = max - min computed in W+1 bits.
  - result_valid=1 and window_cnt increments on that same cycle.
  - Latency is 1 cycle from the last sample to result_valid.
  - Accumulators reset for the next window, so the following sample may arrive in the very next cycle with no gap and no sample lost.
- Result handshake:
  - Result outputs hold stable while result_valid=1 and result_ready=0.
  - On an accept cycle, result_valid drops next cycle unless a new result loads in that same cycle.
  - Simultaneous accept and new-result load: new values load, result_valid stays 1, no overrun.
- Overrun: a window completes while result_valid=1 and there is no accept in that cycle.
  - The new result is discarded and the old result is held.
  - overrun is set to 1. window_cnt still increments, because it counts completed windows, not delivered results.
- overrun clears only via clear_ovr=1 or reset. If set and clear occur in the same cycle, set wins.
- enable deasserted in ACQ: the partial window is discarded and the state goes to IDLE next cycle. Pending results, window_cnt and overrun are preserved.
  - A sample presented in the cycle enable falls is ignored.
- Re-enable always starts a fresh window.
- sample_valid=0 cycles: no state change; gaps of any length are allowed within a window.
- The LOG2_N=1 boundary (N=2) must work identically.

Test Plan:
- W=12, LOG2_N=2, enable=1, samples 100, -20, 300, 40 back-to-back -> 1 cycle after the 4th sample: result_valid=1, mean=105, min_val=-20, max_val=300, pk_pk=320, window_cnt=1.
- Samples -1, -2, -1, -1 -> mean=-2 (floor), min_val=-2, max_val=-1, pk_pk=1. Extremes -2048 and 2047 in one window -> pk_pk=4095, no wrap.
- result_ready held 0 across two full windows -> first result held, overrun=1, window_cnt=2. Then clear_ovr=1 -> overrun=0 next cycle, result unchanged.
- result_ready pulsed exactly on the cycle the second result loads -> result_valid stays 1, outputs show the second window, overrun stays 0.
- enable dropped after 2 of 4 samples, then re-enabled, then 4 samples of 10 -> mean=10, and the partial samples do not contribute. Reset asserted mid-window -> all outputs 0 immediately, without waiting for a clock edge.
- Random sample_valid gaps (0-5 idle cycles) with 1000 random samples -> every result matches the reference model; window_cnt=250.
